// File: rtl/serial_deserializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_deserializer_pkg
//  Purpose  : Shared types for the serial deserializer and its output buffer.
//  Revision : 1.0 - initial release
// ============================================================================
package serial_deserializer_pkg;

    typedef enum logic [0:0] {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage : serial_deserializer_pkg
`default_nettype wire

// File: rtl/serial_deserializer_out_buf.sv
`default_nettype none
// ============================================================================
//  Module   : deser_out_buf
//  Purpose  : One-entry output buffer; flags a completed word it cannot accept.
//  Revision : 1.0 - initial release
// ============================================================================
module deser_out_buf
    import serial_deserializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             drop
);

    buf_state_t       r_state;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= BUF_EMPTY;
            r_data  <= '0;
        end else begin
            case (r_state)
                BUF_EMPTY: begin
                    if (load) begin
                        r_state <= BUF_FULL;
                        r_data  <= load_data;
                    end
                end
                BUF_FULL: begin
                    // A consumed slot may be refilled in the same cycle, so no bubble.
                    if (data_ready) begin
                        if (load) begin
                            r_data <= load_data;
                        end else begin
                            r_state <= BUF_EMPTY;
                        end
                    end
                end
            endcase
        end
    end

    assign data_out   = r_data;
    assign data_valid = (r_state == BUF_FULL);
    assign drop       = (r_state == BUF_FULL) && !data_ready && load;

endmodule : deser_out_buf
`default_nettype wire

// File: rtl/serial_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : serial_deserializer
//  Purpose  : Assembles WIDTH-bit words from a sync-framed serial bit stream.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_deserializer
    import serial_deserializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       serial_in,
    input  logic                       serial_valid,
    input  logic                       sync,
    output logic [WIDTH-1:0]           data_out,
    output logic                       data_valid,
    input  logic                       data_ready,
    output logic [$clog2(WIDTH):0]     bit_count,
    output logic                       overrun
);

    localparam int                 c_CW   = $clog2(WIDTH) + 1;
    localparam logic [c_CW-1:0]    c_LAST = c_CW'(WIDTH - 1);

    // Partial word holds at most WIDTH-1 bits; the final bit goes straight to the buffer.
    logic [WIDTH-2:0] r_shift;
    logic [c_CW-1:0]  r_count;
    logic             r_overrun;

    logic [WIDTH-2:0] w_base;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-2:0] w_partial;
    logic             w_complete;
    logic             w_drop;

    assign w_base     = (serial_valid && sync) ? '0 : r_shift;
    assign w_complete = serial_valid && !sync && (r_count == c_LAST);

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_word    = {w_base, serial_in};
            assign w_partial = w_word[WIDTH-2:0];
        end else begin : g_lsb_first
            assign w_word    = {serial_in, w_base};
            assign w_partial = w_word[WIDTH-1:1];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift   <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (serial_valid) begin
                if (w_complete) begin
                    r_shift <= '0;
                    r_count <= '0;
                end else begin
                    r_shift <= w_partial;
                    r_count <= sync ? c_CW'(1) : r_count + c_CW'(1);
                end
            end else if (sync) begin
                r_shift <= '0;
                r_count <= '0;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    deser_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clock      (clock),
        .reset      (reset),
        .load       (w_complete),
        .load_data  (w_word),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .drop       (w_drop)
    );

    assign bit_count = r_count;
    assign overrun   = r_overrun;

endmodule : serial_deserializer
`default_nettype wire

// File: tb/tb_serial_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_deserializer
//  Purpose  : Bench for MSB-first and LSB-first deserializers fed by a D flop.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_deserializer;

    localparam int W = 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, d, vd, sd, data_ready;
    logic serial_in, serial_valid, sync;

    // Upstream d_flipflop stage feeding both deserializers.
    always_ff @(posedge clock) begin
        serial_in    <= d;
        serial_valid <= vd;
        sync         <= sd;
    end

    logic [W-1:0] dout_m, dout_l;
    logic         valid_m, valid_l, ovr_m, ovr_l;
    logic [3:0]   bc_m, bc_l;

    serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_m (
        .clock(clock), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
        .sync(sync), .data_out(dout_m), .data_valid(valid_m), .data_ready(data_ready),
        .bit_count(bc_m), .overrun(ovr_m)
    );

    serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_l (
        .clock(clock), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
        .sync(sync), .data_out(dout_l), .data_valid(valid_l), .data_ready(data_ready),
        .bit_count(bc_l), .overrun(ovr_l)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: bits of the current word kept in arrival order.
    bit           m_bits[$];
    logic [W-1:0] m_data[2];
    bit           m_valid[2];
    bit           m_ovr[2];
    bit           m_done;
    logic [W-1:0] m_word[2];
    bit           model_on = 1'b0;

    always @(posedge clock) begin
        m_done = 1'b0;
        if (reset) begin
            m_bits.delete();
            for (int k = 0; k < 2; k++) begin
                m_data[k]  = '0;
                m_valid[k] = 1'b0;
                m_ovr[k]   = 1'b0;
            end
        end else begin
            if (serial_valid) begin
                if (sync) m_bits.delete();
                m_bits.push_back(serial_in);
                if (m_bits.size() == W) begin
                    m_done = 1'b1;
                    for (int i = 0; i < W; i++) begin
                        m_word[0][W-1-i] = m_bits[i];
                        m_word[1][i]     = m_bits[i];
                    end
                    m_bits.delete();
                end
            end else if (sync) begin
                m_bits.delete();
            end
            for (int k = 0; k < 2; k++) begin
                if (m_done) begin
                    if (!m_valid[k]) begin
                        m_valid[k] = 1'b1;
                        m_data[k]  = m_word[k];
                    end else if (data_ready) begin
                        m_data[k] = m_word[k];
                    end else begin
                        m_ovr[k] = 1'b1;
                    end
                end else if (m_valid[k] && data_ready) begin
                    m_valid[k] = 1'b0;
                end
            end
        end
        model_on = 1'b1;
    end

    always @(negedge clock) begin
        if (model_on) begin
            check("bit_count_m", bc_m, m_bits.size());
            check("bit_count_l", bc_l, m_bits.size());
            check("valid_m", valid_m, m_valid[0]);
            check("valid_l", valid_l, m_valid[1]);
            check("data_m", dout_m, m_data[0]);
            check("data_l", dout_l, m_data[1]);
            check("overrun_m", ovr_m, m_ovr[0]);
            check("overrun_l", ovr_l, m_ovr[1]);
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            vd = 1'b0; sd = 1'b0;
            @(negedge clock);
        end
    endtask

    task automatic send_bit(input logic b, input logic s);
        d = b; vd = 1'b1; sd = s;
        @(negedge clock);
    endtask

    // Sends w[W-1] first; an optional gap of junk data with serial_valid low mid-word.
    task automatic send_word(input logic [W-1:0] w, input logic s, input bit gap);
        for (int i = W - 1; i >= 0; i--) begin
            if (gap && i == 3) begin
                d = 1'b1; vd = 1'b0; sd = 1'b0;
                repeat (2) @(negedge clock);
            end
            send_bit(w[i], (i == W - 1) ? s : 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1; d = 1'b0; vd = 1'b0; sd = 1'b0; data_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_bit_count", bc_m, 0);
        check("rst_valid", valid_m, 0);
        check("rst_data", dout_m, 0);
        check("rst_overrun", ovr_l, 0);
        reset = 1'b0;

        data_ready = 1'b1;
        send_word(8'hA5, 1'b1, 1'b0);
        idle(1);
        check("a5_data_m", dout_m, 8'hA5);
        check("a5_data_l", dout_l, 8'hA5);
        check("a5_valid", valid_m, 1);
        check("a5_overrun", ovr_m, 0);

        send_word(8'hC0, 1'b0, 1'b1);
        idle(1);
        check("c0_data_m", dout_m, 8'hC0);
        check("c0_data_l", dout_l, 8'h03);
        idle(1);

        data_ready = 1'b0;
        send_word(8'h3C, 1'b0, 1'b0);
        send_word(8'hC3, 1'b0, 1'b0);
        idle(1);
        check("ovr_data_m", dout_m, 8'h3C);
        check("ovr_data_l", dout_l, 8'h3C);
        check("ovr_flag", ovr_m, 1);
        data_ready = 1'b1;
        idle(1);
        data_ready = 1'b0;
        check("ovr_drained", valid_m, 0);

        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("ovr_cleared", ovr_m, 0);

        send_word(8'h11, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b0);
        data_ready = 1'b1;
        idle(1);
        data_ready = 1'b0;
        check("swap_valid", valid_m, 1);
        check("swap_data_m", dout_m, 8'h22);
        check("swap_data_l", dout_l, 8'h44);
        check("swap_overrun", ovr_m, 0);

        data_ready = 1'b1;
        idle(1);
        repeat (3) send_bit(1'b1, 1'b0);
        send_word(8'h5A, 1'b1, 1'b0);
        idle(1);
        check("resync_data_m", dout_m, 8'h5A);
        check("resync_data_l", dout_l, 8'h5A);
        idle(1);

        data_ready = 1'b0;
        send_word(8'h96, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        idle(1);
        check("mid_bit_count", bc_m, 5);
        check("mid_valid", valid_m, 1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("mid_rst_count", bc_m, 0);
        check("mid_rst_valid", valid_l, 0);
        check("mid_rst_data", dout_m, 0);
        data_ready = 1'b1;
        send_word(8'hE1, 1'b0, 1'b0);
        idle(1);
        check("post_rst_data_m", dout_m, 8'hE1);
        check("post_rst_data_l", dout_l, 8'h87);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_deserializer
`default_nettype wire
